// File: rtl/mod_inv_check_pkg.sv
// Shared types and constants for the modular-inverse checker.
// Latencies are counted in clock edges after the capture edge.
package mod_inv_check_pkg;

    typedef enum logic [2:0] {
        IDLE,
        XRED,
        MUL,
        FIX,
        DONE
    } state_e;

    localparam int NBITS_DEF = 2048;

    localparam int CNT_W_DEF      = $clog2(NBITS_DEF + 3);
    localparam int LAT_SIGN_DEF   = 2 * NBITS_DEF + 4;
    localparam int LAT_NOSIGN_DEF = 2 * NBITS_DEF + 1;
    localparam int LAT_ERR        = 1;

    function automatic int cnt_width(input int nbits);
        return $clog2(nbits + 3);
    endfunction

    function automatic int lat_sign(input int nbits);
        return 2 * nbits + 4;
    endfunction

    function automatic int lat_nosign(input int nbits);
        return 2 * nbits + 1;
    endfunction

endpackage

// File: rtl/mod_inv_check_dbl.sv
// One bit-serial modular step: r_o = (2*r_i + bit_i*addend_i) mod n_i.
// Requires r_i < n_i and addend_i < n_i, so at most two subtractions.
module mod_dbl_add_red #(
    parameter int NBITS = 8
) (
    input  logic [NBITS-1:0] r_i,
    input  logic [NBITS-1:0] addend_i,
    input  logic [NBITS-1:0] n_i,
    input  logic             bit_i,
    output logic [NBITS-1:0] r_o
);

    localparam int W = NBITS + 2;

    logic [W-1:0] nw;
    logic [W-1:0] t;
    logic [W-1:0] s1;
    logic [W-1:0] s2;
    logic         unused_hi;

    // Double, add, then fold back into [0, n) with two conditional subtracts.
    always_comb begin
        nw = {2'b00, n_i};
        t  = {1'b0, r_i, 1'b0} + (bit_i ? {2'b00, addend_i} : '0);
        s1 = (t >= nw) ? (t - nw) : t;
        s2 = (s1 >= nw) ? (s1 - nw) : s1;
        r_o = s2[NBITS-1:0];
    end

    assign unused_hi = ^s2[W-1:NBITS];

endmodule

// File: rtl/mod_inv_check.sv
// Verifies a Bezout coefficient: prod = a*x mod n, pass = (prod == gcd).
// MOD_INV_CHECK_SIGN_EN enables signed a (NBITS+3 bits) and final negation.
import mod_inv_check_pkg::*;

module mod_inv_check #(
    parameter int NBITS = NBITS_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable_p,
    input  logic [NBITS-1:0] x,
    input  logic [NBITS-1:0] n,
    input  logic [NBITS+2:0] a,
    input  logic [NBITS-1:0] gcd,
    output logic [NBITS-1:0] prod,
    output logic             pass,
    output logic             err,
    output logic             busy,
    output logic             done_irq_p
);

    localparam int CW = cnt_width(NBITS);
`ifdef MOD_INV_CHECK_SIGN_EN
    localparam int AW = NBITS + 3;
`else
    localparam int AW = NBITS;
`endif
    localparam logic [CW-1:0] XRED_LAST = CW'(NBITS - 1);
    localparam logic [CW-1:0] MUL_LAST  = CW'(AW - 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [NBITS-1:0] x_q, x_d;
    logic [NBITS-1:0] n_q, n_d;
    logic [NBITS-1:0] gcd_q, gcd_d;
    logic [AW-1:0]    aa_q, aa_d;
    logic [NBITS-1:0] r_q, r_d;
    logic [NBITS-1:0] xr_q, xr_d;
    logic [NBITS-1:0] prod_q, prod_d;
    logic             pass_q, pass_d;
    logic             err_q, err_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
`ifdef MOD_INV_CHECK_SIGN_EN
    logic             neg_q, neg_d;
`else
    logic             unused_a;
`endif

    logic [NBITS-1:0] step_r;
    logic [NBITS-1:0] step_add;
    logic             step_bit;

`ifndef MOD_INV_CHECK_SIGN_EN
    assign unused_a = ^a[NBITS+2:NBITS];
`endif

    // XRED injects x bits with addend 1; MUL scans |a| against xr.
    assign step_bit = (state_q == MUL) ? aa_q[AW-1] : x_q[NBITS-1];
    assign step_add = (state_q == MUL) ? xr_q : NBITS'(1);

    mod_dbl_add_red #(
        .NBITS(NBITS)
    ) u_step (
        .r_i      (r_q),
        .addend_i (step_add),
        .n_i      (n_q),
        .bit_i    (step_bit),
        .r_o      (step_r)
    );

    // Next-state and datapath control for the check sequence.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        n_d     = n_q;
        gcd_d   = gcd_q;
        aa_d    = aa_q;
        r_d     = r_q;
        xr_d    = xr_q;
        prod_d  = prod_q;
        pass_d  = pass_q;
        err_d   = err_q;
`ifdef MOD_INV_CHECK_SIGN_EN
        neg_d   = neg_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (enable_p) begin
                    x_d    = x;
                    n_d    = n;
                    gcd_d  = gcd;
`ifdef MOD_INV_CHECK_SIGN_EN
                    neg_d  = a[NBITS+2];
                    aa_d   = a[NBITS+2] ? (~a + AW'(1)) : a;
`else
                    aa_d   = a[NBITS-1:0];
`endif
                    r_d    = '0;
                    cnt_d  = XRED_LAST;
                    prod_d = '0;
                    pass_d = 1'b0;
                    err_d  = 1'b0;
                    if (n == '0) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = XRED;
                    end
                end
            end
            XRED: begin
                x_d = x_q << 1;
                if (cnt_q == '0) begin
                    xr_d    = step_r;
                    r_d     = '0;
                    cnt_d   = MUL_LAST;
                    state_d = MUL;
                end else begin
                    r_d   = step_r;
                    cnt_d = cnt_q - CW'(1);
                end
            end
            MUL: begin
                aa_d = aa_q << 1;
                r_d  = step_r;
                if (cnt_q == '0) begin
                    state_d = FIX;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            FIX: begin
`ifdef MOD_INV_CHECK_SIGN_EN
                prod_d = (neg_q && r_q != '0) ? (n_q - r_q) : r_q;
`else
                prod_d = r_q;
`endif
                pass_d  = (prod_d == gcd_q);
                state_d = IDLE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_q == FIX) || (state_q == DONE);
    end

    // Register all state; reset returns to IDLE with quiet outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            x_q     <= '0;
            n_q     <= '0;
            gcd_q   <= '0;
            aa_q    <= '0;
            r_q     <= '0;
            xr_q    <= '0;
            prod_q  <= '0;
            pass_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef MOD_INV_CHECK_SIGN_EN
            neg_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            n_q     <= n_d;
            gcd_q   <= gcd_d;
            aa_q    <= aa_d;
            r_q     <= r_d;
            xr_q    <= xr_d;
            prod_q  <= prod_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef MOD_INV_CHECK_SIGN_EN
            neg_q   <= neg_d;
`endif
        end
    end

    assign prod       = prod_q;
    assign pass       = pass_q;
    assign err        = err_q;
    assign busy       = busy_q;
    assign done_irq_p = done_q;

endmodule

// File: tb/tb_mod_inv_check.sv
// Randomized and directed bench for mod_inv_check at NBITS=8.
// Reference model uses plain signed arithmetic on the inputs.
module tb_mod_inv_check;

    localparam int NB = 8;
`ifdef MOD_INV_CHECK_SIGN_EN
    localparam int LAT = 2 * NB + 4;
`else
    localparam int LAT = 2 * NB + 1;
`endif

    logic          clk;
    logic          rst;
    logic          enable_p;
    logic [NB-1:0] x;
    logic [NB-1:0] n;
    logic [NB+2:0] a;
    logic [NB-1:0] gcd;
    logic [NB-1:0] prod;
    logic          pass;
    logic          err;
    logic          busy;
    logic          done_irq_p;

    int n_tests = 0;
    int n_fail  = 0;

    mod_inv_check #(
        .NBITS(NB)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable_p   (enable_p),
        .x          (x),
        .n          (n),
        .a          (a),
        .gcd        (gcd),
        .prod       (prod),
        .pass       (pass),
        .err        (err),
        .busy       (busy),
        .done_irq_p (done_irq_p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // a*x mod n straight from the arithmetic definition.
    function automatic logic [NB-1:0] model(input logic [NB-1:0] xi,
                                            input logic [NB-1:0] ni,
                                            input logic [NB+2:0] ai);
        longint av;
        longint p;
        if (ni == 0) return '0;
`ifdef MOD_INV_CHECK_SIGN_EN
        av = ai[NB+2] ? (longint'(ai) - 2048) : longint'(ai);
`else
        av = longint'(ai[NB-1:0]);
`endif
        p = (av * longint'(xi)) % longint'(ni);
        if (p < 0) p = p + longint'(ni);
        return NB'(p);
    endfunction

    task automatic run_op(input logic [NB-1:0] xi, input logic [NB-1:0] ni,
                          input logic [NB+2:0] ai, input logic [NB-1:0] gi,
                          input int repulse_at);
        logic [NB-1:0] ep;
        logic          ex_pass;
        logic          ex_err;
        int            lat;
        int            seen;
        int            pulses;
        logic [NB-1:0] g_prod;
        logic          g_pass;
        logic          g_err;
        logic          g_busy;
        ep      = model(xi, ni, ai);
        ex_err  = (ni == 0);
        ex_pass = !ex_err && (ep == gi);
        lat     = ex_err ? 1 : LAT;
        g_prod  = '0;
        g_pass  = 1'b0;
        g_err   = 1'b0;
        g_busy  = 1'b1;
        @(negedge clk);
        x = xi;
        n = ni;
        a = ai;
        gcd = gi;
        enable_p = 1'b1;
        @(posedge clk);
        #1;
        enable_p = 1'b0;
        x = NB'($urandom);
        n = NB'($urandom);
        a = (NB+3)'($urandom);
        gcd = NB'($urandom);
        check("busy_rise", 32'(busy), 32'd1);
        seen = 0;
        pulses = 0;
        for (int k = 1; k <= lat + 3; k++) begin
            @(posedge clk);
            #1;
            enable_p = 1'b0;
            if (done_irq_p) begin
                pulses++;
                if (seen == 0) begin
                    seen = k;
                    g_prod = prod;
                    g_pass = pass;
                    g_err = err;
                    g_busy = busy;
                end
            end
            if (k == repulse_at) begin
                x = NB'($urandom);
                n = NB'($urandom_range(1, 255));
                a = (NB+3)'($urandom);
                gcd = NB'($urandom);
                enable_p = 1'b1;
            end
        end
        enable_p = 1'b0;
        check("done_edge", 32'(seen), 32'(lat));
        check("done_pulses", 32'(pulses), 32'd1);
        check("prod", 32'(g_prod), 32'(ep));
        check("pass", 32'(g_pass), 32'(ex_pass));
        check("err", 32'(g_err), 32'(ex_err));
        check("busy_at_done", 32'(g_busy), 32'd0);
        check("prod_hold", 32'(prod), 32'(ep));
        check("busy_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        int pulses;
        logic [NB-1:0] rx;
        logic [NB-1:0] rn;
        logic [NB+2:0] ra;
        logic [NB-1:0] rg;
        rst = 1'b1;
        enable_p = 1'b0;
        x = '0;
        n = '0;
        a = '0;
        gcd = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_prod", 32'(prod), 32'd0);
        check("rst_pass", 32'(pass), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done_irq_p), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op(8'd49, 8'd28, -11'sd5, 8'd7, 0);
        run_op(8'd3, 8'd7, 11'd5, 8'd1, 0);
        run_op(8'd3, 8'd7, 11'd4, 8'd1, 0);
        run_op(8'd1, 8'd255, -11'sd1024, 8'd0, 0);
        run_op(8'd1, 8'd255, 11'd0, 8'd0, 0);
        run_op(8'd77, 8'd0, -11'sd3, 8'd0, 0);
        run_op(8'd200, 8'd251, 11'd1023, 8'd5, 12);
        run_op(8'd3, 8'd7, 11'd5, 8'd1, 0);

        // Reset in the middle of XRED must quiet everything at once.
        @(negedge clk);
        x = 8'd49;
        n = 8'd28;
        a = -11'sd5;
        gcd = 8'd7;
        enable_p = 1'b1;
        @(posedge clk);
        #1;
        enable_p = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_prod", 32'(prod), 32'd0);
        check("mid_rst_pass", 32'(pass), 32'd0);
        check("mid_rst_err", 32'(err), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done_irq_p), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int k = 0; k < LAT + 8; k++) begin
            @(posedge clk);
            #1;
            if (done_irq_p) pulses++;
        end
        check("mid_rst_no_done", 32'(pulses), 32'd0);
        run_op(8'd3, 8'd7, 11'd5, 8'd1, 0);

        for (int i = 0; i < 24; i++) begin
            rx = NB'($urandom);
            rn = ($urandom_range(0, 7) == 0) ? '0 : NB'($urandom);
            ra = (NB+3)'($urandom);
            rg = $urandom_range(0, 1) ? model(rx, rn, ra) : NB'($urandom);
            run_op(rx, rn, ra, rg, (i % 4 == 0) ? 10 : 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
